// File: rtl/fb_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fb_write_scheduler                                         |
// | Description : Time-shares the single frame-buffer write stream among     |
// |               N_SRC pixel producers. Each frame_trigger runs one pass    |
// |               over the enabled sources in index order: start handshake, |
// |               beat routing, done handshake.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clock, reset         system clock, synchronous active-high reset       |
// |   i_frame_trigger      1-cycle pass request                              |
// |   i_src_en             per-source enable, latched at pass start          |
// |   o_src_start          start request to source i (registered, held)      |
// |   i_src_start_ack      start acknowledge from source i                   |
// |   i_src_done           source i finished (held until done ack)           |
// |   o_src_done_ack       1-cycle done acknowledge to source i              |
// |   i_src_dout           source beats, source i at [i*DW +: DW]            |
// |   i_src_valid          beat valid per source                             |
// |   o_src_ready          ready back to the current source only             |
// |   o_dout, o_valid      merged beat stream to the write FIFO              |
// |   i_ready              write FIFO ready                                  |
// |   o_busy               pass in progress                                  |
// |   o_pass_done          1-cycle pulse at end of pass                      |
// |   o_missed             saturating count of dropped triggers              |
// +--------------------------------------------------------------------------+
module fb_write_scheduler #(
  parameter int N_SRC = 2,
  parameter int DW    = 54
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_frame_trigger,
  input  logic [N_SRC-1:0]    i_src_en,
  output logic [N_SRC-1:0]    o_src_start,
  input  logic [N_SRC-1:0]    i_src_start_ack,
  input  logic [N_SRC-1:0]    i_src_done,
  output logic [N_SRC-1:0]    o_src_done_ack,
  input  logic [N_SRC*DW-1:0] i_src_dout,
  input  logic [N_SRC-1:0]    i_src_valid,
  output logic [N_SRC-1:0]    o_src_ready,
  output logic [DW-1:0]       o_dout,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_pass_done,
  output logic [7:0]          o_missed
);

  // cur must be able to hold N_SRC itself, which marks "all sources visited"
  localparam int            CW     = $clog2(N_SRC + 1);
  localparam logic [CW-1:0] C_LAST = CW'(N_SRC);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_ACK    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]       r_state;
  logic [CW-1:0]    r_cur;
  logic [N_SRC-1:0] r_en_lat;
  logic [N_SRC-1:0] r_start;
  logic             r_pending;
  logic [7:0]       r_missed;

  logic [N_SRC-1:0] w_cur_oh;
  logic             w_cur_en;
  logic             w_cur_ack;
  logic             w_cur_done;
  logic [DW-1:0]    w_dout;
  logic             w_valid;
  logic [N_SRC-1:0] w_ready;

  // One-hot of the current source; all zero once cur reaches N_SRC, which
  // masks every per-source handshake from non-current sources.
  for (genvar g = 0; g < N_SRC; g++) begin : g_cur_oh
    assign w_cur_oh[g] = (r_cur == CW'(g));
  end

  assign w_cur_en   = |(r_en_lat & w_cur_oh);
  assign w_cur_ack  = |(i_src_start_ack & w_cur_oh);
  assign w_cur_done = |(i_src_done & w_cur_oh);

  // Zero-latency routing of the current source onto the write stream
  always_comb begin
    w_dout  = '0;
    w_valid = 1'b0;
    w_ready = '0;
    if (r_state == S_RUN) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (w_cur_oh[i]) begin
          w_valid    = i_src_valid[i];
          w_dout     = i_src_dout[i*DW +: DW];
          w_ready[i] = i_ready;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cur     <= '0;
      r_en_lat  <= '0;
      r_start   <= '0;
      r_pending <= 1'b0;
      r_missed  <= '0;
    end else begin
      // One-deep trigger queue while a pass runs; further triggers are lost
      if (i_frame_trigger && (r_state != S_IDLE)) begin
        if (!r_pending) begin
          r_pending <= 1'b1;
        end else if (r_missed != 8'hFF) begin
          r_missed <= r_missed + 8'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_frame_trigger || r_pending) begin
            r_en_lat  <= i_src_en;
            r_cur     <= '0;
            r_pending <= 1'b0;
            r_state   <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (r_cur == C_LAST) begin
            r_state <= S_FINISH;
          end else if (!w_cur_en) begin
            r_cur <= r_cur + 1'b1;
          end else begin
            r_start <= w_cur_oh;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_cur_ack) begin
            r_start <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_cur_done) begin
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_cur   <= r_cur + 1'b1;
          r_state <= S_SELECT;
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_src_start    = r_start;
  assign o_src_done_ack = (r_state == S_ACK) ? w_cur_oh : '0;
  assign o_src_ready    = w_ready;
  assign o_dout         = w_dout;
  assign o_valid        = w_valid;
  assign o_busy         = (r_state != S_IDLE);
  assign o_pass_done    = (r_state == S_FINISH);
  assign o_missed       = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fb_write_scheduler                                      |
// | Description : Self-checking bench for fb_write_scheduler (N_SRC=2).     |
// |               Behavioural producers answer the start/done handshakes,   |
// |               a queue holds the beats expected on the merged stream.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fb_write_scheduler;

  localparam int N  = 2;
  localparam int DW = 54;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            i_frame_trigger = 1'b0;
  logic [N-1:0]    i_src_en = '0;
  logic [N-1:0]    i_src_start_ack = '0;
  logic [N-1:0]    i_src_done = '0;
  logic [N*DW-1:0] i_src_dout = '0;
  logic [N-1:0]    i_src_valid = '0;
  logic            i_ready = 1'b1;
  logic [N-1:0]    o_src_start;
  logic [N-1:0]    o_src_done_ack;
  logic [N-1:0]    o_src_ready;
  logic [DW-1:0]   o_dout;
  logic            o_valid;
  logic            o_busy;
  logic            o_pass_done;
  logic [7:0]      o_missed;

  fb_write_scheduler #(.N_SRC(N), .DW(DW)) dut (
    .clock           (clock),
    .reset           (reset),
    .i_frame_trigger (i_frame_trigger),
    .i_src_en        (i_src_en),
    .o_src_start     (o_src_start),
    .i_src_start_ack (i_src_start_ack),
    .i_src_done      (i_src_done),
    .o_src_done_ack  (o_src_done_ack),
    .i_src_dout      (i_src_dout),
    .i_src_valid     (i_src_valid),
    .o_src_ready     (o_src_ready),
    .o_dout          (o_dout),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_busy          (o_busy),
    .o_pass_done     (o_pass_done),
    .o_missed        (o_missed)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] sb[$];

  // Producer model state
  int            nbeats[N] = '{default: 0};
  int            tagv[N]   = '{default: 0};
  int            sent[N]   = '{default: 0};
  logic [DW-1:0] sdout[N]  = '{default: '0};
  logic [N-1:0]  inrun = '0, sdly = '0, sack = '0, sval = '0, sdone = '0;
  logic [N-1:0]  ackph = '0, xfer = '0, early_done = '0;
  logic          rst_was = 1'b1;

  int pass_cnt = 0;
  int dack_cnt[N]  = '{default: 0};
  int start_cnt[N] = '{default: 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input int i, input int t, input int k);
    return {4'(1 << i), 1'(t & 1), 17'(t * 64 + k),
            32'(32'hC0DE0000 + (i << 12) + (t << 6) + k)};
  endfunction

  // Producers act on the falling edge using what happened at the previous
  // rising edge; 2 time units later the monitor samples the settled values
  // that the next rising edge will see.
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      ackph[i] = 1'b0;
      if (rst_was) begin
        inrun[i] = 1'b0; sdly[i] = 1'b0; sack[i] = 1'b0;
        sval[i]  = 1'b0; sdone[i] = 1'b0; sent[i] = 0; sdout[i] = '0;
      end else begin
        if (inrun[i] && sdone[i]) begin
          inrun[i] = 1'b0;
          ackph[i] = 1'b1;
        end
        if (sack[i]) begin
          inrun[i] = 1'b1;
          sent[i]  = 0;
        end
        if (o_src_done_ack[i]) sdone[i] = 1'b0;
        if (o_src_start[i]) begin
          if (sdly[i]) sack[i] = 1'b1;
          else         sdly[i] = 1'b1;
        end else begin
          sack[i] = 1'b0;
          sdly[i] = 1'b0;
        end
        if (inrun[i] && !sdone[i]) begin
          if (xfer[i]) sent[i]++;
          if (sent[i] < nbeats[i]) begin
            sval[i]  = 1'b1;
            sdout[i] = beat(i, tagv[i], sent[i]);
          end else begin
            sval[i]  = 1'b0;
            sdone[i] = 1'b1;
          end
        end
      end
      i_src_valid[i]          = sval[i];
      i_src_start_ack[i]      = sack[i];
      i_src_done[i]           = sdone[i] | early_done[i];
      i_src_dout[i*DW +: DW]  = sdout[i];
    end

    #2;
    rst_was = reset;
    for (int i = 0; i < N; i++) xfer[i] = sval[i] & o_src_ready[i] & ~reset;
    if (!reset) begin : mon
      logic          exp_v;
      logic [DW-1:0] exp_d;
      logic [N-1:0]  exp_r;
      logic [DW-1:0] e;
      exp_v = 1'b0;
      exp_d = '0;
      exp_r = '0;
      for (int i = 0; i < N; i++) begin
        if (inrun[i]) begin
          exp_v    = sval[i];
          exp_d    = sdout[i];
          exp_r[i] = i_ready;
        end
      end
      chk("valid", o_valid, exp_v);
      chk("dout", o_dout, exp_d);
      chk("src_ready", o_src_ready, exp_r);
      chk("done_ack", o_src_done_ack, ackph);
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          chk("beat_extra", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("beat", o_dout, e);
        end
      end
      if (o_pass_done) pass_cnt++;
      for (int i = 0; i < N; i++) begin
        dack_cnt[i]  += int'(o_src_done_ack[i]);
        start_cnt[i] += int'(o_src_start[i]);
      end
    end
  end

  task automatic load(input int i, input int t, input int n, input int copies);
    nbeats[i] = n;
    tagv[i]   = t;
    for (int c = 0; c < copies; c++) ;
  endtask

  task automatic expect_beats(input int i, input int t, input int n);
    for (int k = 0; k < n; k++) sb.push_back(beat(i, t, k));
  endtask

  task automatic clear_counts();
    pass_cnt = 0;
    for (int i = 0; i < N; i++) begin
      dack_cnt[i]  = 0;
      start_cnt[i] = 0;
    end
  endtask

  task automatic trig();
    @(negedge clock);
    i_frame_trigger = 1'b1;
    @(negedge clock);
    i_frame_trigger = 1'b0;
  endtask

  task automatic wait_passes(input int target, input int budget);
    int c;
    c = 0;
    while ((pass_cnt < target || o_busy) && c < budget) begin
      @(negedge clock);
      c++;
    end
    n_chk++;
    assert (c < budget) else begin
      n_fail++;
      $error("FAIL timeout_pass observed=%0d expected=%0d", pass_cnt, target);
    end
  endtask

  task automatic wait_inrun(input int i, input int budget);
    int c;
    c = 0;
    while (!inrun[i] && c < budget) begin
      @(negedge clock);
      #3;
      c++;
    end
    chk("reach_run", inrun[i], 1'b1);
  endtask

  initial begin
    // ---------------- reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_dout", o_dout, '0);
    chk("rst_missed", o_missed, 8'd0);
    chk("rst_start", o_src_start, '0);
    chk("rst_pass_done", o_pass_done, 1'b0);
    reset = 1'b0;

    // ---------------- 1: both sources, 4 beats each
    expect_beats(0, 1, 4);
    expect_beats(1, 2, 4);
    load(0, 1, 4, 1);
    load(1, 2, 4, 1);
    i_src_en = 2'b11;
    clear_counts();
    trig();
    wait_passes(1, 300);
    chk("t1_sb_left", sb.size(), 0);
    chk("t1_pass", pass_cnt, 1);
    chk("t1_dack0", dack_cnt[0], 1);
    chk("t1_dack1", dack_cnt[1], 1);
    chk("t1_start0_cycles", start_cnt[0], 2);

    // ---------------- 2: ready toggling
    expect_beats(0, 3, 3);
    expect_beats(1, 4, 3);
    load(0, 3, 3, 1);
    load(1, 4, 3, 1);
    clear_counts();
    trig();
    repeat (60) begin
      @(negedge clock);
      i_ready = ~i_ready;
    end
    i_ready = 1'b1;
    wait_passes(1, 300);
    chk("t2_sb_left", sb.size(), 0);
    chk("t2_pass", pass_cnt, 1);

    // ---------------- 3: src0 disabled, mid-pass enable change ignored
    expect_beats(1, 5, 2);
    load(1, 5, 2, 1);
    clear_counts();
    i_src_en = 2'b10;
    trig();
    i_src_en = 2'b11;
    wait_passes(1, 300);
    chk("t3_start0", start_cnt[0], 0);
    chk("t3_dack0", dack_cnt[0], 0);
    chk("t3_dack1", dack_cnt[1], 1);
    chk("t3_pass", pass_cnt, 1);
    chk("t3_sb_left", sb.size(), 0);

    // all disabled: pass_done exactly 3 edges after the trigger is sampled
    clear_counts();
    i_src_en = 2'b00;
    trig();
    chk("t3z_busy", o_busy, 1'b1);
    @(negedge clock);
    chk("t3z_pd_e1", o_pass_done, 1'b0);
    @(negedge clock);
    chk("t3z_pd_e2", o_pass_done, 1'b0);
    @(negedge clock);
    chk("t3z_pd_e3", o_pass_done, 1'b1);
    @(negedge clock);
    chk("t3z_pd_e4", o_pass_done, 1'b0);
    chk("t3z_idle", o_busy, 1'b0);
    chk("t3z_starts", start_cnt[0] + start_cnt[1], 0);

    // ---------------- 4: pending + missed, then saturation
    i_src_en = 2'b11;
    for (int p = 0; p < 2; p++) begin
      expect_beats(0, 6, 20);
      expect_beats(1, 7, 2);
    end
    load(0, 6, 20, 1);
    load(1, 7, 2, 1);
    clear_counts();
    trig();
    repeat (3) trig();
    chk("t4_missed2", o_missed, 8'd2);
    wait_passes(2, 600);
    chk("t4_pass", pass_cnt, 2);
    chk("t4_dack0", dack_cnt[0], 2);
    chk("t4_dack1", dack_cnt[1], 2);
    chk("t4_sb_left", sb.size(), 0);

    for (int p = 0; p < 2; p++) begin
      expect_beats(0, 8, 1);
      expect_beats(1, 9, 1);
    end
    load(0, 8, 1, 1);
    load(1, 9, 1, 1);
    clear_counts();
    i_ready = 1'b0;
    @(negedge clock);
    i_frame_trigger = 1'b1;
    repeat (300) @(negedge clock);
    i_frame_trigger = 1'b0;
    chk("t4_missed_sat", o_missed, 8'd255);
    i_ready = 1'b1;
    wait_passes(2, 600);
    chk("t4s_pass", pass_cnt, 2);
    chk("t4s_sb_left", sb.size(), 0);
    chk("t4s_missed", o_missed, 8'd255);

    // ---------------- 5: reset during RUN of src1
    expect_beats(0, 10, 2);
    expect_beats(1, 11, 10);
    load(0, 10, 2, 1);
    load(1, 11, 10, 1);
    clear_counts();
    trig();
    wait_inrun(1, 200);
    @(negedge clock);
    reset   = 1'b1;
    i_ready = 1'b0;
    @(negedge clock);
    chk("t5_busy", o_busy, 1'b0);
    chk("t5_start", o_src_start, '0);
    chk("t5_ready", o_src_ready, '0);
    chk("t5_dack", o_src_done_ack, '0);
    chk("t5_valid", o_valid, 1'b0);
    chk("t5_dout", o_dout, '0);
    chk("t5_missed", o_missed, 8'd0);
    reset   = 1'b0;
    i_ready = 1'b1;
    sb.delete();
    expect_beats(0, 12, 1);
    expect_beats(1, 13, 1);
    load(0, 12, 1, 1);
    load(1, 13, 1, 1);
    @(negedge clock);
    clear_counts();
    trig();
    begin : find_start
      int c;
      c = 0;
      while (o_src_start == '0 && c < 20) begin
        @(negedge clock);
        c++;
      end
    end
    chk("t5_first_start", o_src_start, 2'b01);
    wait_passes(1, 200);
    chk("t5_sb_left", sb.size(), 0);

    // ---------------- 6: done from non-current source ignored
    expect_beats(0, 14, 6);
    expect_beats(1, 15, 2);
    load(0, 14, 6, 1);
    load(1, 15, 2, 1);
    clear_counts();
    trig();
    wait_inrun(0, 50);
    @(negedge clock);
    early_done[1] = 1'b1;
    repeat (2) @(negedge clock);
    early_done[1] = 1'b0;
    wait_passes(1, 200);
    chk("t6_dack0", dack_cnt[0], 1);
    chk("t6_dack1", dack_cnt[1], 1);
    chk("t6_sb_left", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
